// File: rtl/model_pkg.sv
// Shared result-word definitions for the inference output path.
package model_pkg;

  localparam int unsigned RES_W       = 32;
  localparam int unsigned FRAME_WORDS = 4096;

  typedef struct packed {
    logic             last;
    logic [RES_W-1:0] data;
  } res_word_t;

endpackage

// File: rtl/out_axis_packer_sync_fifo.sv
// Synchronous FIFO with BRAM-style storage: registered read, unreset data array,
// wrap-bit pointers and a registered occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // Storage and registered read port; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    if (rd_en) rd_data <= mem[rd_ptr[AW-1:0]];
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ONE;
      if (rd_en) rd_ptr <= rd_ptr + ONE;
      unique case ({wr_en, rd_en})
        2'b10:   level <= level + ONE;
        2'b01:   level <= level - ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/out_axis_packer.sv
// Buffers the un-throttleable result stream and re-emits it as an AXI4-Stream
// master with TLAST per frame, stall request, and drop accounting.
module out_axis_packer
  import model_pkg::*;
#(
  parameter int unsigned DATA_W       = RES_W,
  parameter int unsigned FIFO_DEPTH   = 512,
  parameter int unsigned FRAME_WORDS  = model_pkg::FRAME_WORDS,
  parameter int unsigned STALL_MARGIN = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic [DATA_W-1:0]           m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        stall_req,
  output logic                        overflow,
  output logic [15:0]                 drop_count,
  input  logic                        clear_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CW = $clog2(FRAME_WORDS);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_WORDS - 1);

  logic [CW-1:0]   in_cnt;
  logic            in_last;
  logic [DATA_W:0] rd_data;
  logic            fifo_full;
  logic            fifo_empty;
  logic            inflight;
  logic            load;
  logic            rd_en;
  logic            bypass;
  logic            wr_en;
  logic            drop;
  logic [LW-1:0]   level_next;

  // Output register may take a new word when empty or when its word is leaving.
  // A word read from the FIFO lands one cycle later (inflight), and while
  // nothing is buffered or in flight the input word is loaded directly so the
  // write-to-output latency stays at one cycle.
  always_comb begin
    in_last    = (in_cnt == CNT_LAST);
    load       = !m_axis_tvalid || m_axis_tready;
    rd_en      = !fifo_empty && load;
    bypass     = in_valid && fifo_empty && !inflight && load;
    wr_en      = in_valid && !bypass && (!fifo_full || rd_en);
    drop       = in_valid && fifo_full && !rd_en;
    level_next = fifo_level;
    if (wr_en && !rd_en)      level_next = fifo_level + LVL_ONE;
    else if (!wr_en && rd_en) level_next = fifo_level - LVL_ONE;
  end

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data ({in_last, in_data}),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Frame position counter; advances on every strobe, dropped or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_cnt <= '0;
    else if (in_valid) in_cnt <= in_last ? '0 : in_cnt + CNT_ONE;
  end

  // Output stage: holds data stable under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      inflight      <= 1'b0;
    end else begin
      inflight <= rd_en || (inflight && !load);
      if (load) begin
        if (inflight) begin
          {m_axis_tlast, m_axis_tdata} <= rd_data;
          m_axis_tvalid <= 1'b1;
        end else if (bypass) begin
          {m_axis_tlast, m_axis_tdata} <= {in_last, in_data};
          m_axis_tvalid <= 1'b1;
        end else begin
          m_axis_tvalid <= 1'b0;
        end
      end
    end
  end

  // Stall request tracks the occupancy the FIFO will hold after this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_req <= 1'b0;
    else        stall_req <= (LW'(FIFO_DEPTH) - level_next) <= LW'(STALL_MARGIN);
  end

  // Sticky overflow and saturating drop count; a drop wins over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= clear_err ? 16'd1 :
                    (drop_count == 16'hFFFF) ? drop_count : drop_count + 16'd1;
    end else if (clear_err) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_out_axis_packer.sv
// Scoreboard bench for out_axis_packer: the driver predicts the stream from
// frame-position arithmetic, a negedge monitor pops and compares on handshakes.
module tb_out_axis_packer;
  import model_pkg::*;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned FW     = 8;
  localparam int unsigned MARGIN = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        stall_req;
  logic        overflow;
  logic [15:0] drop_count;
  logic        clear_err = 1'b0;
  logic [4:0]  fifo_level;

  int          checks = 0;
  int          failures = 0;
  int unsigned wc = 0;
  res_word_t   exp_q[$];
  logic        held_v = 1'b0;
  logic [32:0] held_w = '0;

  out_axis_packer #(
    .DATA_W       (32),
    .FIFO_DEPTH   (DEPTH),
    .FRAME_WORDS  (FW),
    .STALL_MARGIN (MARGIN)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .stall_req     (stall_req),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .clear_err     (clear_err),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every strobe occupies one frame position; accepted words are expected out.
  task automatic send(input logic [31:0] d, input bit accept);
    res_word_t e;
    in_data  = d;
    in_valid = 1'b1;
    if (accept) begin
      e.last = ((wc % FW) == FW - 1);
      e.data = d;
      exp_q.push_back(e);
    end
    wc++;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    clear_err = 1'b0;
    exp_q.delete();
    wc = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    m_axis_tready = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    tick();
    check("drain_tvalid", m_axis_tvalid, 0);
  endtask

  // Monitor: compare on each handshake and enforce stability under back-pressure.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("hold_tvalid", m_axis_tvalid, 1);
        check("hold_data", {m_axis_tlast, m_axis_tdata}, held_w);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stream_extra: got 0x%0h expected no word", {m_axis_tlast, m_axis_tdata});
        end else begin
          res_word_t e;
          e = exp_q.pop_front();
          check("stream", {m_axis_tlast, m_axis_tdata}, {e.last, e.data});
        end
      end
      held_v = m_axis_tvalid && !m_axis_tready;
      held_w = {m_axis_tlast, m_axis_tdata};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_stall", stall_req, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drops", drop_count, 0);
    check("rst_level", fifo_level, 0);
    rst_n = 1'b1;

    // Single word: one-cycle latency
    m_axis_tready = 1'b1;
    send(32'hDEAD_BEEF, 1);
    check("single_tvalid", m_axis_tvalid, 1);
    check("single_tdata", m_axis_tdata, 32'hDEAD_BEEF);
    check("single_tlast", m_axis_tlast, 0);
    check("single_level", fifo_level, 0);
    drain();

    // Frame boundary: 16 consecutive words
    do_reset();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 16; i++) send(32'(i), 1);
    drain();

    // Back-pressure: 10 words while stalled
    m_axis_tready = 1'b0;
    for (int i = 0; i < 10; i++) send(32'h100 + 32'(i), 1);
    check("bp_peak_level", fifo_level, 9);
    repeat (3) tick();
    drain();

    // Stall and overflow: 20 words into a 16-deep FIFO, output blocked
    do_reset();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      int unsigned lvl;
      send(32'hA000_0000 + 32'(i), i < 17);
      lvl = (i < 16) ? i : 16;
      check("ovf_level", fifo_level, lvl);
      check("ovf_stall", stall_req, (DEPTH - lvl) <= MARGIN);
    end
    check("ovf_flag", overflow, 1);
    check("ovf_drops", drop_count, 3);

    // Full FIFO with simultaneous pop and write
    m_axis_tready = 1'b1;
    send(32'hB0B0_0001, 1);
    m_axis_tready = 1'b0;
    check("fullpw_level", fifo_level, 16);
    check("fullpw_drops", drop_count, 3);

    // Clear error state
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("clr_overflow", overflow, 0);
    check("clr_drops", drop_count, 0);
    drain();

    // Reset mid-frame
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'hC000_0000 + 32'(i), 1);
    check("pre_rst_tvalid", m_axis_tvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tvalid", m_axis_tvalid, 0);
    check("async_rst_level", fifo_level, 0);
    exp_q.delete();
    wc = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < FW; i++) send($urandom, 1);
    drain();

    // Random traffic honouring stall_req
    for (int i = 0; i < 400; i++) begin
      m_axis_tready = ($urandom_range(0, 3) != 0);
      if (!stall_req && $urandom_range(0, 9) < 7) send($urandom, 1);
      else tick();
    end
    drain();
    check("rand_overflow", overflow, 0);
    check("rand_drops", drop_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
